// File: rtl/pipeline_stream_checker.sv
// pipeline_stream_checker: checks a pipeline's output stream against an arithmetic sequence and drives a periodic global stall
module pipeline_stream_checker #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] EXP_START    = '0,
  parameter logic [DATA_W-1:0] EXP_STEP     = {{(DATA_W-1){1'b0}}, 1'b1},
  parameter int                NUM_WORDS    = 64,
  parameter int                STALL_PERIOD = 8,
  parameter int                STALL_LEN    = 2,
  parameter int                CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              stall,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [DATA_W-1:0] first_err,
  output logic              err_flag,
  output logic              busy,
  output logic              done
);
  localparam int PW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [PW-1:0] LAST = PW'(STALL_PERIOD - 1);
  localparam logic [PW-1:0] ON = PW'(STALL_PERIOD - STALL_LEN);
  localparam bit STALL_EN = (STALL_PERIOD >= 2) && (STALL_LEN > 0);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [DATA_W-1:0] expected;
  logic accept, last_word, launch;
  assign accept = (state == RUN) && in_valid && !stall;
  assign last_word = word_count == CNT_W'(NUM_WORDS - 1);
  assign launch = (state != RUN) && start;
  assign phase_n = (phase == LAST) ? '0 : phase + PW'(1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = (state != RUN) ? (start ? RUN : state) : ((accept && last_word) ? FIN : RUN);
  end
  always_comb begin
    busy = state == RUN;
    done = state == FIN;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall      <= 1'b0;
      word_count <= '0;
      err_count  <= '0;
      first_err  <= '0;
      err_flag   <= 1'b0;
      expected   <= EXP_START;
      phase      <= '0;
    end else if (launch) begin
      stall      <= 1'b0;
      word_count <= '0;
      err_count  <= '0;
      first_err  <= '0;
      err_flag   <= 1'b0;
      expected   <= EXP_START;
      phase      <= '0;
    end else if (state == RUN) begin
      phase <= phase_n;
      // stall drops on the completing edge so DONE never holds the pipeline
      stall <= STALL_EN && !(accept && last_word) && (phase_n >= ON);
      if (accept) begin
        word_count <= word_count + CNT_W'(1);
        expected   <= expected + EXP_STEP;
        if (in_data != expected) begin
          err_count <= (err_count == '1) ? err_count : err_count + CNT_W'(1);
          err_flag  <= 1'b1;
          if (!err_flag) first_err <= in_data;
        end
      end
    end else begin
      stall <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipeline_stream_checker.sv
// tb_pipeline_stream_checker: directed + randomized checks of pipeline_stream_checker against a sequence-level model
module tb_pipeline_stream_checker;
  logic clk = 0, reset = 0, start = 0, in_valid = 0;
  logic [31:0] in_data = '0;
  logic stall, err_flag, busy, done;
  logic [15:0] word_count, err_count;
  logic [31:0] first_err;
  logic w_start = 0, w_valid = 0;
  logic [31:0] w_data = '0;
  logic w_stall, w_err_flag, w_busy, w_done;
  logic [15:0] w_wc, w_ec;
  logic [31:0] w_first;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  pipeline_stream_checker dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .word_count(word_count), .err_count(err_count), .first_err(first_err),
    .err_flag(err_flag), .busy(busy), .done(done)
  );

  pipeline_stream_checker #(.EXP_START(32'hFFFF_FFFE), .NUM_WORDS(4)) u_wrap (
    .clk(clk), .reset(reset), .start(w_start), .in_data(w_data), .in_valid(w_valid),
    .stall(w_stall), .word_count(w_wc), .err_count(w_ec), .first_err(w_first),
    .err_flag(w_err_flag), .busy(w_busy), .done(w_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_wc"}, word_count, 0);
    chk({tag, "_ec"}, err_count, 0);
    chk({tag, "_first"}, first_err, 0);
    chk({tag, "_flag"}, err_flag, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode 0: valid only on unstalled cycles, 1: valid always, 2: random valid
  task automatic run_pass(input int mode, input int stop, input int bad_a, input logic [31:0] val_a,
                          input int bad_b, input logic [31:0] val_b);
    int acc = 0, errs = 0, cyc = 0, guard = 0;
    logic [31:0] first = '0, word;
    bit v, st;
    start = 1;
    step();
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("wc_after_start", word_count, 0);
    chk("stall_after_start", stall, 0);
    while (acc < stop && guard < 2000) begin
      st = (cyc % 8) >= 6;
      chk("stall_pattern", stall, st);
      v = (mode == 0) ? !st : (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      word = (acc == bad_a) ? val_a : (acc == bad_b) ? val_b : 32'(acc);
      in_valid = v;
      in_data = word;
      step();
      if (v && !st) begin
        if (word != 32'(acc)) begin
          if (errs == 0) first = word;
          errs++;
        end
        acc++;
      end
      cyc++;
      guard++;
      chk("word_count", word_count, acc);
      chk("err_count", err_count, errs);
    end
    in_valid = 0;
    chk("cycle_budget", guard < 2000, 1);
    if (stop == 64) begin
      chk("done", done, 1);
      chk("busy_end", busy, 0);
      chk("stall_end", stall, 0);
      chk("err_flag", err_flag, errs != 0);
      chk("first_err", first_err, first);
      in_valid = 1;
      in_data = 32'h1234;
      repeat (3) step();
      in_valid = 0;
      chk("wc_frozen", word_count, 64);
      chk("ec_frozen", err_count, errs);
      chk("done_hold", done, 1);
      chk("stall_done", stall, 0);
    end
  endtask

  initial begin
    logic [31:0] wrap_seq [4];
    wrap_seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    #1;
    chk_cleared("reset");
    step();
    chk_cleared("idle");
    run_pass(0, 64, -1, 0, -1, 0);
    run_pass(1, 64, -1, 0, -1, 0);
    chk("bp_err_flag", err_flag, 0);
    run_pass(2, 64, 5, 32'hDEAD, 9, 32'hBEEF);
    chk("inj_ec", err_count, 2);
    chk("inj_first", first_err, 32'hDEAD);
    chk("inj_flag", err_flag, 1);
    w_start = 1;
    step();
    w_start = 0;
    for (int i = 0; i < 4; i++) begin
      w_valid = 1;
      w_data = wrap_seq[i];
      step();
      chk("wrap_wc", w_wc, i + 1);
    end
    w_valid = 0;
    chk("wrap_ec", w_ec, 0);
    chk("wrap_flag", w_err_flag, 0);
    chk("wrap_done", w_done, 1);
    run_pass(1, 20, -1, 0, -1, 0);
    chk("mid_busy", busy, 1);
    #2 reset = 0;
    #1;
    chk_cleared("mid_reset");
    @(negedge clk) reset = 1;
    step();
    chk_cleared("post_reset");
    run_pass(2, 64, -1, 0, -1, 0);
    chk("rerun_ec", err_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
